// File: rtl/risc_y_controller.sv
// Sequencing control unit for the 8-bit RISC-Y CPU: 8-phase fetch/execute FSM with
// opcode-decoded control lines. Optional single-step gate: define RISCY_CTRL_STEP_EN.
module risc_y_controller #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
`ifdef RISCY_CTRL_STEP_EN
  input  logic             STEP,
`endif
  input  logic [2:0]       OPCODE,
  input  logic             ZERO,
  output logic             SEL,
  output logic             RD,
  output logic             WR,
  output logic             LD_IR,
  output logic             LD_AC,
  output logic             LD_PC,
  output logic             INC_PC,
  output logic             DATA_E,
  output logic             HALT,
  output logic [2:0]       PHASE,
  output logic [CNT_W-1:0] INSTR_COUNT
);

  localparam int unsigned OP_W = 3;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  phase_t           phase_q, phase_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic op_hlt, op_skz, op_sto, op_jmp, aluop;

  assign op_hlt = (OPCODE == OP_W'(0));
  assign op_skz = (OPCODE == OP_W'(1));
  assign op_sto = (OPCODE == OP_W'(6));
  assign op_jmp = (OPCODE == OP_W'(7));
  assign aluop  = (OPCODE == OP_W'(2)) || (OPCODE == OP_W'(3)) ||
                  (OPCODE == OP_W'(4)) || (OPCODE == OP_W'(5));

  // State register; reset wins over any pending halt or count increment.
  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    SEL      = 1'b0;
    RD       = 1'b0;
    WR       = 1'b0;
    LD_IR    = 1'b0;
    LD_AC    = 1'b0;
    LD_PC    = 1'b0;
    INC_PC   = 1'b0;
    DATA_E   = 1'b0;
    HALT     = 1'b0;

    if (halted_q) begin
      HALT = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR: begin
          SEL = 1'b1;
`ifdef RISCY_CTRL_STEP_EN
          if (STEP) phase_d = INST_FETCH;
`else
          phase_d = INST_FETCH;
`endif
        end
        INST_FETCH: begin
          SEL     = 1'b1;
          RD      = 1'b1;
          phase_d = INST_LOAD;
        end
        INST_LOAD: begin
          SEL     = 1'b1;
          RD      = 1'b1;
          LD_IR   = 1'b1;
          phase_d = IDLE;
        end
        IDLE: begin
          SEL     = 1'b1;
          RD      = 1'b1;
          LD_IR   = 1'b1;
          phase_d = OP_ADDR;
        end
        OP_ADDR: begin
          HALT   = op_hlt;
          INC_PC = !op_hlt;
          // HLT parks the FSM here until reset.
          if (op_hlt) halted_d = 1'b1;
          else        phase_d  = OP_FETCH;
        end
        OP_FETCH: begin
          RD      = aluop;
          phase_d = ALU_OP;
        end
        ALU_OP: begin
          RD      = aluop;
          INC_PC  = op_skz & ZERO;
          LD_PC   = op_jmp;
          DATA_E  = op_sto;
          phase_d = STORE;
        end
        STORE: begin
          RD      = aluop;
          LD_AC   = aluop;
          INC_PC  = op_jmp;
          LD_PC   = op_jmp;
          WR      = op_sto;
          DATA_E  = op_sto;
          phase_d = INST_ADDR;
          cnt_d   = cnt_q + CNT_W'(1);
        end
        default: phase_d = INST_ADDR;
      endcase
    end
  end

  assign PHASE       = phase_q;
  assign INSTR_COUNT = cnt_q;

endmodule

// File: tb/tb_risc_y_controller.sv
// Self-checking bench for risc_y_controller: table-driven instruction vectors with a
// per-cycle expected-output scoreboard, plus reset, halt, wraparound and step sequences.
module tb_risc_y_controller;

  localparam int unsigned CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             STEP;
  logic [2:0]       OPCODE;
  logic             ZERO;
  logic             SEL, RD, WR, LD_IR, LD_AC, LD_PC, INC_PC, DATA_E, HALT;
  logic [2:0]       PHASE;
  logic [CNT_W-1:0] INSTR_COUNT;

  always #5 CLK = ~CLK;

  risc_y_controller #(.CNT_W(CNT_W)) dut (
    .CLK(CLK),
    .RST(RST),
`ifdef RISCY_CTRL_STEP_EN
    .STEP(STEP),
`endif
    .OPCODE(OPCODE),
    .ZERO(ZERO),
    .SEL(SEL),
    .RD(RD),
    .WR(WR),
    .LD_IR(LD_IR),
    .LD_AC(LD_AC),
    .LD_PC(LD_PC),
    .INC_PC(INC_PC),
    .DATA_E(DATA_E),
    .HALT(HALT),
    .PHASE(PHASE),
    .INSTR_COUNT(INSTR_COUNT)
  );

  // Per-phase masks (bit i = phase i) of each opcode-dependent control line.
  typedef struct packed {
    logic [2:0] op;
    logic       zero;
    logic [7:0] rd;
    logic [7:0] inc;
    logic [7:0] ldpc;
    logic [7:0] ldac;
    logic [7:0] wr;
    logic [7:0] de;
  } vec_t;

  // Control word layout: {SEL,RD,WR,LD_IR,LD_AC,LD_PC,INC_PC,DATA_E,HALT}
  typedef struct packed {
    logic [2:0] phase;
    logic [8:0] ctl;
  } exp_t;

  localparam logic [8:0] CTL_IDLE0  = 9'b1_0000_0000;
  localparam logic [8:0] CTL_HALTED = 9'b0_0000_0001;

  exp_t             sb_q[$];
  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] cnt_m;
  vec_t             vecs[8];
  vec_t             v_add;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] ctl_word(input vec_t v, input int p);
    logic sel, ldir;
    sel  = (p < 4);
    ldir = (p == 2) || (p == 3);
    return {sel, v.rd[p], v.wr[p], ldir, v.ldac[p], v.ldpc[p], v.inc[p], v.de[p], 1'b0};
  endfunction

  function automatic logic [8:0] dut_ctl();
    return {SEL, RD, WR, LD_IR, LD_AC, LD_PC, INC_PC, DATA_E, HALT};
  endfunction

  // Drive inputs for one cycle, queue the expectation, compare, then advance to next edge.
  task automatic cycle(input string name, input logic [2:0] op, input logic z, input exp_t e);
    exp_t got;
    OPCODE = op;
    ZERO   = z;
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    check($sformatf("%s phase", name), 32'(PHASE), 32'(got.phase));
    check($sformatf("%s ctl", name), 32'(dut_ctl()), 32'(got.ctl));
    @(posedge CLK);
    #1;
  endtask

  task automatic run_phases(input string name, input vec_t v, input int first, input int last);
    for (int p = first; p <= last; p++)
      cycle($sformatf("%s p%0d", name, p), v.op, v.zero, exp_t'{3'(p), ctl_word(v, p)});
  endtask

  task automatic run_instr(input string name, input vec_t v);
    check($sformatf("%s count_before", name), 32'(INSTR_COUNT), 32'(cnt_m));
    run_phases(name, v, 0, 7);
    cnt_m = cnt_m + CNT_W'(1);
  endtask

  task automatic check_reset_state(input string name);
    check($sformatf("%s phase", name), 32'(PHASE), 32'd0);
    check($sformatf("%s ctl", name), 32'(dut_ctl()), 32'(CTL_IDLE0));
    check($sformatf("%s count", name), 32'(INSTR_COUNT), 32'd0);
  endtask

  initial begin
    RST    = 1'b1;
    STEP   = 1'b1;
    OPCODE = 3'd0;
    ZERO   = 1'b0;
    cnt_m  = '0;

    //            op    z     rd     inc    ldpc   ldac   wr     de
    vecs[0] = '{3'd5, 1'b0, 8'hEE, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00}; // LDA
    vecs[1] = '{3'd6, 1'b0, 8'h0E, 8'h10, 8'h00, 8'h00, 8'h80, 8'hC0}; // STO
    vecs[2] = '{3'd1, 1'b1, 8'h0E, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00}; // SKZ taken
    vecs[3] = '{3'd1, 1'b0, 8'h0E, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}; // SKZ not taken
    vecs[4] = '{3'd7, 1'b1, 8'h0E, 8'h90, 8'hC0, 8'h00, 8'h00, 8'h00}; // JMP
    vecs[5] = '{3'd2, 1'b1, 8'hEE, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00}; // ADD
    vecs[6] = '{3'd3, 1'b0, 8'hEE, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00}; // AND
    vecs[7] = '{3'd4, 1'b1, 8'hEE, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00}; // XOR
    v_add   = vecs[5];

    repeat (2) @(posedge CLK);
    #1;
    check_reset_state("por");
    RST = 1'b0;

    for (int i = 0; i < 8; i++) run_instr($sformatf("vec%0d", i), vecs[i]);
    check("count after table", 32'(INSTR_COUNT), 32'(cnt_m));

    // Reset held two cycles from the middle of phase 5.
    run_phases("rst5", vecs[0], 0, 4);
    RST = 1'b1;
    @(posedge CLK); #1;
    check_reset_state("rst5 first");
    @(posedge CLK); #1;
    check_reset_state("rst5 second");
    RST   = 1'b0;
    cnt_m = '0;

    // Reset in phase 7 must suppress the pending count increment.
    run_instr("pre", vecs[1]);
    run_phases("rst7", vecs[0], 0, 6);
    check("rst7 p7 phase", 32'(PHASE), 32'd7);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST   = 1'b0;
    cnt_m = '0;
    check_reset_state("rst7");

    // Sixteen ADDs wrap the 4-bit counter 15 -> 0.
    for (int i = 0; i < 16; i++) run_instr($sformatf("add%0d", i), v_add);
    check("wrap count", 32'(INSTR_COUNT), 32'd0);
    run_instr("add_post", v_add);
    check("post-wrap count", 32'(INSTR_COUNT), 32'd1);

    // HLT: normal fetch, HALT in phase 4, then parked regardless of inputs.
    begin
      vec_t v_hlt;
      v_hlt = '{3'd0, 1'b0, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_phases("hlt", v_hlt, 0, 3);
      cycle("hlt p4", 3'd0, 1'b1, exp_t'{3'd4, CTL_HALTED});
      for (int i = 0; i < 20; i++)
        cycle($sformatf("halted%0d", i), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              exp_t'{3'd4, CTL_HALTED});
      check("halt count", 32'(INSTR_COUNT), 32'(cnt_m));
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST   = 1'b0;
    cnt_m = '0;
    check_reset_state("hlt rst");
    run_instr("after_hlt", vecs[0]);
    check("after hlt count", 32'(INSTR_COUNT), 32'd1);

`ifdef RISCY_CTRL_STEP_EN
    // Step gating: phase 0 holds until STEP is sampled high.
    STEP = 1'b0;
    RST  = 1'b1;
    @(posedge CLK); #1;
    RST   = 1'b0;
    cnt_m = '0;
    for (int i = 0; i < 10; i++)
      cycle($sformatf("step_hold%0d", i), 3'd5, 1'b0, exp_t'{3'd0, CTL_IDLE0});
    STEP = 1'b1;
    cycle("step p0", vecs[0].op, 1'b0, exp_t'{3'd0, ctl_word(vecs[0], 0)});
    STEP = 1'b0;
    run_phases("step", vecs[0], 1, 7);
    cnt_m = cnt_m + CNT_W'(1);
    for (int i = 0; i < 5; i++)
      cycle($sformatf("step_after%0d", i), 3'd5, 1'b0, exp_t'{3'd0, CTL_IDLE0});
    check("step count", 32'(INSTR_COUNT), 32'(cnt_m));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
